// File: rtl/countdown_timer.sv
// Free-running down-counter that reloads from D whenever it reaches zero.
// The period is D+1 cycles, and zero flags the single all-zeros cycle of each period.

module nor_zero #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic             y
);

    assign y = ~|a;

endmodule

// Q is valid on every cycle; there is no handshake. zero is a combinational view of Q.
module countdown_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             zero
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    nor_zero #(.WIDTH(WIDTH)) u_nor_zero (
        .a (Q),
        .y (zero)
    );

    // Q == 0 always takes the reload path, so the decrement never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Q <= '0;
        end else if (zero) begin
            Q <= D;
        end else begin
            Q <= Q - ONE;
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized bench for countdown_timer: a period-level reference model fills a
// scoreboard queue on each clock edge, and a negedge monitor drains and compares it.

module tb_countdown_timer;

    localparam int WIDTH = 4;
    localparam int W     = WIDTH + 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [WIDTH-1:0] D     = '0;
    logic [WIDTH-1:0] Q;
    logic             zero;

    logic [WIDTH-1:0] nor_in = '0;
    logic             nor_out;

    logic [W-1:0]     exp_q[$];
    logic [WIDTH-1:0] seq_q[$];

    int total = 0;
    int bad   = 0;

    countdown_timer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .Q     (Q),
        .zero  (zero)
    );

    nor_zero #(.WIDTH(WIDTH)) u_nor (
        .a (nor_in),
        .y (nor_out)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One period is the sequence D, D-1, ..., 0, with D taken at the edge that
    // starts the period. When the pending sequence is used up, a new one begins.
    always @(posedge clk) begin
        logic [WIDTH-1:0] nxt;
        if (!rst_n) begin
            seq_q.delete();
            exp_q.push_back({1'b1, {WIDTH{1'b0}}});
        end else begin
            if (seq_q.size() == 0) begin
                for (int v = int'(D); v >= 0; v--) seq_q.push_back(WIDTH'(v));
            end
            nxt = seq_q.pop_front();
            exp_q.push_back({(nxt == 0), nxt});
        end
    end

    // Reset drops the period in progress, and any output not yet sampled becomes 0.
    always @(negedge rst_n) begin
        seq_q.delete();
        foreach (exp_q[i]) exp_q[i] = {1'b1, {WIDTH{1'b0}}};
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("sb_q", int'(Q), int'(e[WIDTH-1:0]));
            chk("sb_zero", int'(zero), int'(e[WIDTH]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_for_q(input logic [WIDTH-1:0] val, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk);
            #1;
            if (Q == val) found = 1'b1;
        end
    endtask

    task automatic reset_pulse_midcycle();
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_q", int'(Q), 0);
        chk("async_rst_zero", int'(zero), 1);
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit found;
        int max_q;

        // Exhaustive check of the zero detector on its own.
        for (int v = 0; v < 16; v++) begin
            nor_in = WIDTH'(v);
            #1;
            chk("nor_exhaustive", int'(nor_out), (v == 0) ? 1 : 0);
        end

        // Reset and first load.
        D = 4'd8;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", int'(Q), 0);
        chk("reset_zero", int'(zero), 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_load_q", int'(Q), 8);
        chk("first_load_zero", int'(zero), 0);

        // Steady count, D = 8.
        max_q = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (int'(Q) > max_q) max_q = int'(Q);
        end
        chk("steady_max_q", max_q, 8);

        // D change mid-count: new value takes effect at the next reload.
        wait_for_q(4'd5, 20, found);
        chk("find_q5_a", int'(found), 1);
        D = 4'd3;
        cycles(15);

        // Edge values.
        D = 4'd0;
        cycles(20);
        D = 4'd15;
        cycles(40);

        // Asynchronous reset between edges while Q = 5.
        D = 4'd9;
        wait_for_q(4'd5, 40, found);
        chk("find_q5_b", int'(found), 1);
        reset_pulse_midcycle();
        @(posedge clk);
        #1;
        chk("post_rst_load", int'(Q), 9);
        cycles(12);

        // Randomized D with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) D = WIDTH'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
            @(posedge clk);
            #1;
        end

        @(negedge clk);
        #1;
        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule
